// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: regfile port widths, write-enable
// polarity, load funct3 codes and the load misalignment rule.
package wb_stage_pkg;

  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;

  localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = 5'd0;
  localparam logic                   WRITE_ENABLE = 1'b1;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic load_misaligned(input logic [2:0] load_type,
                                           input logic [1:0] addr_lo);
    logic mis;
    case (load_type)
      LOAD_LH, LOAD_LHU: mis = addr_lo[0];
      LOAD_LW:           mis = (addr_lo != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data aligner: selects the addressed byte/half of a bus word
// and sign- or zero-extends it to a full register value.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]             load_type,
  input  logic [1:0]             addr_lo,
  input  logic [RDATA_WIDTH-1:0] rdata,
  output logic [RDATA_WIDTH-1:0] wdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the low address bits.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by load type; unknown codes pass the word through.
  always_comb begin
    wdata = rdata;
    case (load_type)
      LOAD_LB:  wdata = {{24{byte_s[7]}}, byte_s};
      LOAD_LH:  wdata = {{16{half_s[15]}}, half_s};
      LOAD_LW:  wdata = rdata;
      LOAD_LBU: wdata = {24'h000000, byte_s};
      LOAD_LHU: wdata = {16'h0000, half_s};
      default:  wdata = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires MEM results into the regfile write port, waiting for
// load data (with timeout) and aligning it before the registered write.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_valid_i,
  output logic                   mem_ready_o,
  input  logic                   mem_we_i,
  input  logic [RADDR_WIDTH-1:0] mem_waddr_i,
  input  logic [RDATA_WIDTH-1:0] mem_wdata_i,
  input  logic                   mem_is_load_i,
  input  logic [2:0]             mem_load_type_i,
  input  logic [1:0]             mem_addr_lo_i,
  input  logic                   bus_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] bus_rdata_i,
  output logic                   we_o,
  output logic [RADDR_WIDTH-1:0] waddr_o,
  output logic [RDATA_WIDTH-1:0] wdata_o,
  output logic                   retire_o,
  output logic                   err_o
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

  state_e                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [RADDR_WIDTH-1:0] ld_waddr_r, ld_waddr_s;
  logic [2:0]             ld_type_r, ld_type_s;
  logic [1:0]             ld_addr_lo_r, ld_addr_lo_s;
  logic                   we_s, retire_s, err_s;
  logic [RADDR_WIDTH-1:0] waddr_s;
  logic [RDATA_WIDTH-1:0] wdata_s, align_data_s;
  logic                   accept_s;

  assign mem_ready_o = (state_r == ST_IDLE);
  assign accept_s    = mem_valid_i & mem_ready_o;

  load_align u_load_align (
    .load_type (ld_type_r),
    .addr_lo   (ld_addr_lo_r),
    .rdata     (bus_rdata_i),
    .wdata     (align_data_s)
  );

  // Next state, load context and next output values.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    ld_waddr_s   = ld_waddr_r;
    ld_type_s    = ld_type_r;
    ld_addr_lo_s = ld_addr_lo_r;
    we_s         = 1'b0;
    retire_s     = 1'b0;
    err_s        = 1'b0;
    waddr_s      = waddr_o;
    wdata_s      = wdata_o;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !mem_is_load_i) begin
          retire_s = 1'b1;
          we_s     = (mem_we_i == WRITE_ENABLE) && (mem_waddr_i != ZERO_REG);
          if (we_s) begin
            waddr_s = mem_waddr_i;
            wdata_s = mem_wdata_i;
          end else begin
            waddr_s = waddr_o;
          end
        end else if (accept_s && load_misaligned(mem_load_type_i, mem_addr_lo_i)) begin
          retire_s = 1'b1;
          err_s    = 1'b1;
        end else if (accept_s) begin
          ld_waddr_s   = mem_waddr_i;
          ld_type_s    = mem_load_type_i;
          ld_addr_lo_s = mem_addr_lo_i;
          cnt_s        = '0;
          state_s      = ST_LOAD_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_WAIT: begin
        // A response in the final timeout cycle still completes the load.
        if (bus_rvalid_i) begin
          retire_s = 1'b1;
          we_s     = (ld_waddr_r != ZERO_REG);
          if (we_s) begin
            waddr_s = ld_waddr_r;
            wdata_s = align_data_s;
          end else begin
            waddr_s = waddr_o;
          end
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_s   = 1'b1;
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, load context and registered regfile-port outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      ld_waddr_r   <= '0;
      ld_type_r    <= 3'b000;
      ld_addr_lo_r <= 2'b00;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      retire_o     <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      ld_waddr_r   <= ld_waddr_s;
      ld_type_r    <= ld_type_s;
      ld_addr_lo_r <= ld_addr_lo_s;
      we_o         <= we_s;
      waddr_o      <= waddr_s;
      wdata_o      <= wdata_s;
      retire_o     <= retire_s;
      err_o        <= err_s;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a shortened load timeout.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_valid_i, mem_ready_o, mem_we_i, mem_is_load_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  mem_load_type_i;
  logic [1:0]  mem_addr_lo_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        we_o, retire_o, err_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int checks   = 0;
  int failures = 0;

  wb_stage #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .mem_is_load_i(mem_is_load_i), .mem_load_type_i(mem_load_type_i),
    .mem_addr_lo_i(mem_addr_lo_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .retire_o(retire_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_waddr_i = 5'd0; mem_wdata_i = 32'h0;
    mem_is_load_i = 1'b0; mem_load_type_i = 3'b000; mem_addr_lo_i = 2'b00;
  endtask

  task automatic send(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ld, input logic [2:0] ty, input logic [1:0] lo);
    mem_valid_i = 1'b1; mem_we_i = we; mem_waddr_i = wa; mem_wdata_i = wd;
    mem_is_load_i = ld; mem_load_type_i = ty; mem_addr_lo_i = lo;
  endtask

  task automatic chk_pulses(input string tag, input logic we, input logic ret, input logic er);
    check({tag, ".we"}, {31'd0, we_o}, {31'd0, we});
    check({tag, ".retire"}, {31'd0, retire_o}, {31'd0, ret});
    check({tag, ".err"}, {31'd0, err_o}, {31'd0, er});
  endtask

  // Aligned load table: type, addr_lo, raw word, expected write data.
  logic [2:0]  lt_type [4] = '{3'b101, 3'b001, 3'b100, 3'b010};
  logic [1:0]  lt_lo   [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
  logic [31:0] lt_raw  [4] = '{32'hBEEF1234, 32'h00008001, 32'h0000A500, 32'hCAFEF00D};
  logic [31:0] lt_exp  [4] = '{32'h0000BEEF, 32'hFFFF8001, 32'h000000A5, 32'hCAFEF00D};

  initial begin
    rst_i = 1'b1; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    idle_in();
    step(); step();
    chk_pulses("reset", 1'b0, 1'b0, 1'b0);
    check("reset.waddr", {27'd0, waddr_o}, 32'd0);
    check("reset.wdata", wdata_o, 32'd0);
    rst_i = 1'b0;
    check("reset.ready", {31'd0, mem_ready_o}, 32'd1);

    // Plain write retires one cycle later.
    send(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'b000, 2'b00);
    step(); idle_in();
    chk_pulses("nl1", 1'b1, 1'b1, 1'b0);
    check("nl1.waddr", {27'd0, waddr_o}, 32'd5);
    check("nl1.wdata", wdata_o, 32'hDEADBEEF);
    step();
    chk_pulses("nl1.after", 1'b0, 1'b0, 1'b0);
    check("nl1.hold", wdata_o, 32'hDEADBEEF);

    // Write to x0 retires without writing.
    send(1'b1, 5'd0, 32'h12345678, 1'b0, 3'b000, 2'b00);
    step(); idle_in();
    chk_pulses("x0", 1'b0, 1'b1, 1'b0);

    // Back-to-back writes to x1..x3.
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 3'b000, 2'b00);
      step();
      chk_pulses("b2b", 1'b1, 1'b1, 1'b0);
      check("b2b.waddr", {27'd0, waddr_o}, 32'(i));
      check("b2b.wdata", wdata_o, 32'h100 + 32'(i));
    end
    idle_in();

    // LB at byte 3 with a response after four idle wait cycles.
    send(1'b0, 5'd7, 32'h0, 1'b1, 3'b000, 2'd3);
    step(); idle_in();
    for (int k = 0; k < 4; k++) begin
      check("lb.ready_low", {31'd0, mem_ready_o}, 32'd0);
      check("lb.no_we", {31'd0, we_o}, 32'd0);
      step();
    end
    check("lb.ready_low5", {31'd0, mem_ready_o}, 32'd0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h80112233;
    step(); bus_rvalid_i = 1'b0;
    chk_pulses("lb", 1'b1, 1'b1, 1'b0);
    check("lb.waddr", {27'd0, waddr_o}, 32'd7);
    check("lb.wdata", wdata_o, 32'hFFFFFF80);
    check("lb.ready", {31'd0, mem_ready_o}, 32'd1);

    // Aligned loads answered in the first wait cycle.
    for (int j = 0; j < 4; j++) begin
      send(1'b0, 5'd9, 32'h0, 1'b1, lt_type[j], lt_lo[j]);
      step(); idle_in();
      bus_rvalid_i = 1'b1; bus_rdata_i = lt_raw[j];
      step(); bus_rvalid_i = 1'b0;
      chk_pulses("ld", 1'b1, 1'b1, 1'b0);
      check("ld.waddr", {27'd0, waddr_o}, 32'd9);
      check("ld.wdata", wdata_o, lt_exp[j]);
    end

    // Misaligned LW errors immediately and stays ready.
    send(1'b0, 5'd4, 32'h0, 1'b1, 3'b010, 2'd1);
    step(); idle_in();
    chk_pulses("mis", 1'b0, 1'b1, 1'b1);
    check("mis.ready", {31'd0, mem_ready_o}, 32'd1);
    step();
    chk_pulses("mis.after", 1'b0, 1'b0, 1'b0);

    // Timeout after eight wait cycles.
    send(1'b0, 5'd6, 32'h0, 1'b1, 3'b010, 2'd0);
    step(); idle_in();
    for (int k = 0; k < 7; k++) begin
      check("to.wait_err", {31'd0, err_o}, 32'd0);
      check("to.wait_ready", {31'd0, mem_ready_o}, 32'd0);
      step();
    end
    step();
    chk_pulses("to", 1'b0, 1'b0, 1'b1);
    check("to.ready", {31'd0, mem_ready_o}, 32'd1);
    step();
    check("to.err_pulse", {31'd0, err_o}, 32'd0);

    // Stale response in IDLE has no effect.
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    step(); bus_rvalid_i = 1'b0;
    chk_pulses("stale", 1'b0, 1'b0, 1'b0);
    check("stale.wdata", wdata_o, 32'hCAFEF00D);

    // Response in the final timeout cycle completes the load.
    send(1'b0, 5'd11, 32'h0, 1'b1, 3'b010, 2'd0);
    step(); idle_in();
    for (int k = 0; k < 7; k++) step();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BADCAFE;
    step(); bus_rvalid_i = 1'b0;
    chk_pulses("late", 1'b1, 1'b1, 1'b0);
    check("late.wdata", wdata_o, 32'h0BADCAFE);

    // Reset in LOAD_WAIT drops the pending load.
    send(1'b0, 5'd8, 32'h0, 1'b1, 3'b010, 2'd0);
    step(); idle_in();
    step();
    rst_i = 1'b1;
    step(); rst_i = 1'b0;
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    check("rst.wdata", wdata_o, 32'd0);
    check("rst.ready", {31'd0, mem_ready_o}, 32'd1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11111111;
    step(); bus_rvalid_i = 1'b0;
    chk_pulses("rst.rvalid", 1'b0, 1'b0, 1'b0);
    send(1'b1, 5'd10, 32'h000055AA, 1'b0, 3'b000, 2'b00);
    step(); idle_in();
    chk_pulses("rst.nl", 1'b1, 1'b1, 1'b0);
    check("rst.nl.wdata", wdata_o, 32'h000055AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
